neuro_image_feeder: RTL and testbench

Streams one scaled 128×128 RGB888 frame from the scaled-image RAM into the neural-network image memory as three channel-planar, signed 13-bit fixed-point planes in B, G, R order. Sits between the scaled-image RAM read port and the network's image write port. Replaces the ad-hoc x/y counters and step counter with one self-timed start/done sequencer. The network is launched by a separate controller after `done`.

---
 rtl/neuro_image_feeder.sv | 110 +++++++++++
 tb/tb_neuro_image_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/neuro_image_feeder.sv
// Streams one scaled RGB888 frame from the scaled-image RAM into the network
// image memory as three channel-planar signed 13-bit planes (B, G, R).
module neuro_image_feeder #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned PIX_W = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                ram_re,
  output logic [PIX_W-1:0]    ram_addr,
  input  logic [23:0]         ram_data,
  output logic                img_we,
  output logic [PIX_W+1:0]    img_addr,
  output logic signed [12:0]  img_data,
  output logic [1:0]          plane,
  output logic                busy,
  output logic                done
);

  localparam int unsigned         NPIX     = IMG_W * IMG_H;
  localparam logic [PIX_W-1:0]    LAST_PIX = PIX_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [1:0]         plane_q, plane_d;
  logic               we_q;
  logic [PIX_W+1:0]   waddr_q;
  logic [1:0]         sel_q;
  logic [7:0]         chan;
  logic [12:0]        conv;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    plane_d = plane_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pix_d   = '0;
          plane_d = '0;
        end
      end
      S_FETCH: begin
        pix_d = pix_q + 1'b1;
        if (pix_q == LAST_PIX) begin
          if (plane_q == 2'd2) begin
            state_d = S_DRAIN;
            plane_d = '0;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort also beats a simultaneous start while idle.
    if (abort) begin
      state_d = S_IDLE;
      pix_d   = '0;
      plane_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      plane_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      plane_q <= plane_d;
      we_q    <= (state_q == S_FETCH) && !abort;
      waddr_q <= {plane_q, pix_q};
      sel_q   <= plane_q;
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    chan = ram_data[7:0];
      2'd1:    chan = ram_data[15:8];
      default: chan = ram_data[23:16];
    endcase
  end

  // 32*v - 4080 wraps correctly in 13 bits since the result spans -4080..+4080.
  assign conv     = {chan, 5'b0} - 13'd4080;
  assign img_data = we_q ? $signed(conv) : '0;

  assign ram_re   = (state_q == S_FETCH);
  assign ram_addr = pix_q;
  assign plane    = plane_q;
  assign busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done     = (state_q == S_FIN);
  assign img_we   = we_q;
  assign img_addr = waddr_q;

endmodule

// File: tb/tb_neuro_image_feeder.sv
// Scoreboard bench for neuro_image_feeder on a reduced 32x32 geometry.
module tb_neuro_image_feeder;

  localparam int W     = 32;
  localparam int H     = 32;
  localparam int PW    = 10;
  localparam int NPIX  = W * H;
  localparam int NW    = 3 * NPIX;
  localparam int TDONE = NW + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              ram_re;
  logic [PW-1:0]     ram_addr;
  logic [23:0]       ram_data = '0;
  logic              img_we;
  logic [PW+1:0]     img_addr;
  logic signed [12:0] img_data;
  logic [1:0]        plane;
  logic              busy;
  logic              done;

  neuro_image_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ram_re(ram_re), .ram_addr(ram_addr), .ram_data(ram_data),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .plane(plane), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t          wq[$];
  int           rq[$];
  int           mode = 0;
  logic [23:0]  rnd [NPIX];
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] word(input int a);
    logic [13:0] pix;
    pix = 14'(a);
    case (mode)
      0:       word = {pix[7:0], pix[13:6], ~pix[7:0]};
      1:       word = 24'h0080FF;
      default: word = rnd[a];
    endcase
  endfunction

  function automatic int conv(input int v);
    return (2 * v - 255) * 16;
  endfunction

  // RAM model: registered read, data one cycle after the address.
  always @(posedge clk) ram_data <= word(int'(ram_addr));

  always @(negedge clk) begin : monitor
    wr_t e;
    int  ra;
    if (img_we === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", int'(img_addr), e.addr);
        chk("wr_data", int'(img_data), e.data);
      end
    end
    if (ram_re === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        ra = rq.pop_front();
        chk("rd_plane_addr", int'({plane, ram_addr}), ra);
      end
    end
  end

  task automatic frame(input int m, input bit hold, input int cut, input bit use_rst);
    bit  seen;
    wr_t e;
    int  v;
    seen = 1'b0;
    mode = m;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NPIX; i++) begin
        v = int'((word(i) >> (8 * p)) & 24'hFF);
        e.addr = p * NPIX + i;
        if (m == 1) e.data = (p == 0) ? 4080 : (p == 1) ? 16 : -4080;
        else        e.data = conv(v);
        wq.push_back(e);
        rq.push_back(e.addr);
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("busy_T1", int'(busy), 1);
    chk("ram_re_T1", int'(ram_re), 1);
    chk("ram_addr_T1", int'(ram_addr), 0);
    chk("done_T1", int'(done), 0);
    for (int k = 2; k <= TDONE + 4 && !seen; k++) begin
      if (cut != 0 && k == cut) begin
        if (use_rst) rst_n = 1'b0;
        else         abort = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort = 1'b0;
        chk("cut_ram_re", int'(ram_re), 0);
        chk("cut_img_we", int'(img_we), 0);
        chk("cut_busy", int'(busy), 0);
        chk("cut_done", int'(done), 0);
        if (use_rst) begin
          chk("rst_ram_addr", int'(ram_addr), 0);
          chk("rst_img_addr", int'(img_addr), 0);
          chk("rst_img_data", int'(img_data), 0);
          chk("rst_plane", int'(plane), 0);
        end
        wq.delete();
        rq.delete();
        repeat (4) begin
          @(posedge clk); #1;
          chk("no_done_after_cut", int'(done), 0);
          chk("idle_after_cut", int'(busy), 0);
        end
        return;
      end
      @(posedge clk); #1;
      if (k <= NW + 1) begin
        chk("we_stream", int'(img_we), 1);
        chk("addr_stream", int'(img_addr), k - 2);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        chk("done_time", k, TDONE);
        chk("busy_at_done", int'(busy), 0);
      end
    end
    start = 1'b0;
    if (!seen) chk("done_seen", 0, 1);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("single_done", int'(done), 0);
      chk("idle_after_frame", int'(busy), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_re", int'(ram_re), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_img_we", int'(img_we), 0);
    chk("rst_img_addr", int'(img_addr), 0);
    chk("rst_img_data", int'(img_data), 0);
    chk("rst_plane", int'(plane), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    foreach (rnd[i]) rnd[i] = 24'($urandom);
    repeat (2) @(posedge clk);
    #1;

    frame(0, 1'b0, 0, 1'b0);
    frame(1, 1'b0, 0, 1'b0);
    frame(2, 1'b1, 0, 1'b0);
    frame(2, 1'b0, int'($urandom_range(3, NW)), 1'b0);
    frame(0, 1'b0, 0, 1'b0);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", int'(busy), 0);
    chk("abort_wins_re", int'(ram_re), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_wins_idle", int'(busy), 0);
    end

    foreach (rnd[i]) rnd[i] = 24'($urandom);
    frame(2, 1'b0, NPIX + NPIX / 2, 1'b1);
    frame(2, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
